calc_op_sequencer: RTL

Top-level operation scheduler for the calculator datapath. It accepts one operation request, latches the operands, and dispatches the request to one of four shared functional units (add/sub, mult, div, sqrt). It sequences each unit's init/done handshake, captures the result, and clears the unit back to idle. It also rejects illegal requests and aborts hung units via a watchdog.

---
 rtl/calc_op_sequencer_if.sv | 34 +++
 rtl/calc_op_sequencer.sv | 112 +++++++++++
 2 files changed

// File: rtl/calc_op_sequencer_if.sv
// Request, functional-unit and result signals of the calculator op sequencer.
// The sequencer uses the slave view; the requester/unit side uses the master view.
interface calc_op_sequencer_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   unit_a;
  logic [WIDTH-1:0]   unit_b;
  logic               unit_sub;
  logic [3:0]         unit_init;
  logic               unit_clr;
  logic [3:0]         unit_done;
  logic [4*WIDTH-1:0] unit_res;
  logic [WIDTH-1:0]   result;
  logic               valid;
  logic               busy;
  logic               err;
  logic [1:0]         err_code;

  modport slave (
    input  start, op, a, b, unit_done, unit_res,
    output unit_a, unit_b, unit_sub, unit_init, unit_clr,
           result, valid, busy, err, err_code
  );

  modport master (
    output start, op, a, b, unit_done, unit_res,
    input  unit_a, unit_b, unit_sub, unit_init, unit_clr,
           result, valid, busy, err, err_code
  );
endinterface

// File: rtl/calc_op_sequencer.sv
// Dispatches one calculator op to a shared unit, waits for done (watchdog-bounded), captures result.
// Latency: init at k+1, valid at k+N+2; start is only sampled in IDLE, never queued.
module calc_op_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  calc_op_sequencer_if.slave   io
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DISPATCH, S_WAIT, S_CAPTURE, S_ABORT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             sub_q, sub_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       code_q, code_d;
  logic [TW-1:0]    timer_q, timer_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      sel_q   <= 2'd0;
      code_q  <= 2'd0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sub_q   <= sub_d;
      sel_q   <= sel_d;
      code_q  <= code_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sub_d   = sub_q;
    sel_d   = sel_q;
    code_d  = code_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (io.start) begin
          if (io.op > 3'd4) begin
            code_d  = 2'd1;
            state_d = S_ABORT;
          end else if (io.op == 3'd3 && io.b == '0) begin
            code_d  = 2'd2;
            state_d = S_ABORT;
          end else begin
            a_d   = io.a;
            b_d   = io.b;
            sub_d = (io.op == 3'd1);
            case (io.op)
              3'd0, 3'd1: sel_d = 2'd0;
              3'd2:       sel_d = 2'd1;
              3'd3:       sel_d = 2'd2;
              default:    sel_d = 2'd3;
            endcase
            code_d  = 2'd0;
            state_d = S_DISPATCH;
          end
        end
      end
      S_DISPATCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Only the selected unit's done matters; the others may be stale.
        if (io.unit_done[sel_q]) begin
          res_d   = io.unit_res[int'(sel_q)*WIDTH +: WIDTH];
          state_d = S_CAPTURE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          code_d  = 2'd3;
          state_d = S_ABORT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    io.unit_init = 4'b0000;
    if (state_q == S_DISPATCH) io.unit_init[sel_q] = 1'b1;
    io.unit_clr  = !rst || state_q == S_CAPTURE || state_q == S_ABORT;
    io.valid     = (state_q == S_CAPTURE);
    io.err       = (state_q == S_ABORT);
    io.busy      = (state_q != S_IDLE);
    io.unit_a    = a_q;
    io.unit_b    = b_q;
    io.unit_sub  = sub_q;
    io.result    = res_q;
    io.err_code  = code_q;
  end
endmodule
